// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART line arbiter: FSM states, release
// causes and the line-terminating character.
package uart_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        CAUSE_LF       = 2'd0,
        CAUSE_MAX_LINE = 2'd1,
        CAUSE_TIMEOUT  = 2'd2
    } done_cause_e;

    localparam logic [7:0] LF_CHAR = 8'h0A;

endpackage

// File: rtl/uart_rr_sel.sv
// Round-robin pick: finds the first set request bit at or after ptr, wrapping
// around, in a single combinational pass.
module uart_rr_sel #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // NOTE: every variable driven here gets a default before the loop, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_line_arbiter.sv
// Shares one UART transmitter between N_REQ requesters, one whole line at a
// time. Optional stall timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_line_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int MAX_LINE       = 255,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [N_REQ*8-1:0]       req_data_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic                     tx_valid_o,
    output logic [7:0]               tx_data_o,
    input  logic                     tx_ready_i,
    output logic [$clog2(N_REQ)-1:0] owner_o,
    output logic                     locked_o,
    output logic                     line_done_o,
    output logic [1:0]               done_cause_o
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e       state_q, state_d;
    done_cause_e      done_cause_q, cause_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]       byte_cnt_q, byte_cnt_d;
    logic             line_done_q, line_done_d;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] next_ptr;
    logic [7:0]       req_bytes [N_REQ];
    logic             locked;
    logic             owner_valid;
    logic             xfer;
    logic             release_line;

    uart_rr_sel #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_sel (
        .req   (req_valid_i),
        .ptr   (rr_ptr_q),
        .found (sel_found),
        .idx   (sel_idx)
    );

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            req_bytes[k] = req_data_i[k*8 +: 8];
        end
    end

    // Datapath is combinational from the owner's port: no added latency per byte.
    assign locked      = (state_q == ST_LOCKED) && !rst_i;
    assign owner_valid = req_valid_i[owner_q];
    assign tx_valid_o  = locked && owner_valid;
    assign tx_data_o   = req_bytes[owner_q];
    assign xfer        = tx_valid_o && tx_ready_i;
    assign next_ptr    = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        req_ready_o = '0;
        if (locked) begin
            req_ready_o[owner_q] = tx_ready_i;
        end
    end

    assign owner_o      = rst_i ? '0 : owner_q;
    assign locked_o     = locked;
    assign line_done_o  = line_done_q && !rst_i;
    assign done_cause_o = rst_i ? 2'd0 : done_cause_q;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               stall_expired;

    assign stall_expired = locked && !owner_valid &&
                           (stall_cnt_q == STALL_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        stall_cnt_d = '0;
        if (locked && !owner_valid && !release_line) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`else
    logic        stall_expired;
    logic [31:0] timeout_unused;

    assign stall_expired  = 1'b0;
    assign timeout_unused = 32'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        byte_cnt_d   = byte_cnt_q;
        cause_d      = done_cause_q;
        line_done_d  = 1'b0;
        release_line = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_found && !rst_i) begin
                    owner_d = sel_idx;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // LF is tested first so it wins when it is also the last allowed byte.
                if (xfer) begin
                    if (tx_data_o == LF_CHAR) begin
                        release_line = 1'b1;
                        cause_d      = CAUSE_LF;
                    end else if (byte_cnt_q == 8'(MAX_LINE - 1)) begin
                        release_line = 1'b1;
                        cause_d      = CAUSE_MAX_LINE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end else if (stall_expired) begin
                    release_line = 1'b1;
                    cause_d      = CAUSE_TIMEOUT;
                end
                if (release_line) begin
                    state_d     = ST_IDLE;
                    byte_cnt_d  = '0;
                    rr_ptr_d    = next_ptr;
                    line_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            byte_cnt_q   <= '0;
            line_done_q  <= 1'b0;
            done_cause_q <= CAUSE_LF;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            byte_cnt_q   <= byte_cnt_d;
            line_done_q  <= line_done_d;
            done_cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_uart_line_arbiter.sv
// Directed bench for uart_line_arbiter (N_REQ=4, MAX_LINE=4, TIMEOUT_CYCLES=16);
// build with UART_ARB_TIMEOUT_EN defined to exercise the stall timeout.
module tb_uart_line_arbiter;

    localparam int N_REQ          = 4;
    localparam int MAX_LINE       = 4;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int N_VEC          = 40;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [3:0]  req_valid_i = '0;
    logic [31:0] req_data_i = '0;
    logic [3:0]  req_ready_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i = 1'b0;
    logic [1:0]  owner_o;
    logic        locked_o;
    logic        line_done_o;
    logic [1:0]  done_cause_o;

    int checks = 0;
    int errors = 0;

    uart_line_arbiter #(
        .N_REQ          (N_REQ),
        .MAX_LINE       (MAX_LINE),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .tx_valid_o   (tx_valid_o),
        .tx_data_o    (tx_data_o),
        .tx_ready_i   (tx_ready_i),
        .owner_o      (owner_o),
        .locked_o     (locked_o),
        .line_done_o  (line_done_o),
        .done_cause_o (done_cause_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        rdy;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic [3:0]  e_ready;
        logic        e_lock;
        logic [1:0]  e_owner;
        logic        e_done;
        logic [1:0]  e_cause;
    } vec_t;

    vec_t vecs [N_VEC];

    function automatic vec_t v(logic rst, logic [3:0] valid, logic [31:0] data, logic rdy,
                               logic e_txv, logic [7:0] e_txd, logic [3:0] e_ready,
                               logic e_lock, logic [1:0] e_owner, logic e_done,
                               logic [1:0] e_cause);
        vec_t r;
        r.rst = rst;     r.valid = valid;     r.data = data;       r.rdy = rdy;
        r.e_txv = e_txv; r.e_txd = e_txd;     r.e_ready = e_ready; r.e_lock = e_lock;
        r.e_owner = e_owner; r.e_done = e_done; r.e_cause = e_cause;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] valid, input logic [31:0] data,
                         input logic rdy);
        @(negedge clk_i);
        rst_i       = rst;
        req_valid_i = valid;
        req_data_i  = data;
        tx_ready_i  = rdy;
        #2;
    endtask

    initial begin
        //          rst valid  data           rdy  txv txd    ready  lock own done cause
        // single line "AB\n" from req1
        vecs[0]  = v(1, 4'b0000, 32'h0000_0000, 1,  0, 8'h00, 4'b0000, 0, 0, 0, 0);
        vecs[1]  = v(0, 4'b0010, 32'h0000_4100, 1,  0, 8'h00, 4'b0000, 0, 0, 0, 0);
        vecs[2]  = v(0, 4'b0010, 32'h0000_4100, 1,  1, 8'h41, 4'b0010, 1, 1, 0, 0);
        vecs[3]  = v(0, 4'b0010, 32'h0000_4200, 1,  1, 8'h42, 4'b0010, 1, 1, 0, 0);
        vecs[4]  = v(0, 4'b0010, 32'h0000_0A00, 1,  1, 8'h0A, 4'b0010, 1, 1, 0, 0);
        vecs[5]  = v(0, 4'b0000, 32'h0000_0000, 1,  0, 8'h00, 4'b0000, 0, 1, 1, 0);
        vecs[6]  = v(0, 4'b0000, 32'h0000_0000, 1,  0, 8'h00, 4'b0000, 0, 1, 0, 0);
        // contention req0 / req2 from reset
        vecs[7]  = v(1, 4'b0101, 32'h0061_0058, 1,  0, 8'h00, 4'b0000, 0, 0, 0, 0);
        vecs[8]  = v(0, 4'b0101, 32'h0061_0058, 1,  0, 8'h00, 4'b0000, 0, 0, 0, 0);
        vecs[9]  = v(0, 4'b0101, 32'h0061_0058, 1,  1, 8'h58, 4'b0001, 1, 0, 0, 0);
        vecs[10] = v(0, 4'b0101, 32'h0061_000A, 1,  1, 8'h0A, 4'b0001, 1, 0, 0, 0);
        vecs[11] = v(0, 4'b0101, 32'h000A_000A, 1,  0, 8'h00, 4'b0000, 0, 0, 1, 0);
        vecs[12] = v(0, 4'b0101, 32'h000A_000A, 1,  1, 8'h0A, 4'b0100, 1, 2, 0, 0);
        vecs[13] = v(0, 4'b0101, 32'h000A_000A, 1,  0, 8'h00, 4'b0000, 0, 2, 1, 0);
        vecs[14] = v(0, 4'b0101, 32'h000A_000A, 1,  1, 8'h0A, 4'b0001, 1, 0, 0, 0);
        // max line: req3 streams 0x55, then LF landing on the 4th byte
        vecs[15] = v(0, 4'b1000, 32'h5500_0000, 1,  0, 8'h00, 4'b0000, 0, 0, 1, 0);
        vecs[16] = v(0, 4'b1000, 32'h5500_0000, 1,  1, 8'h55, 4'b1000, 1, 3, 0, 0);
        vecs[17] = v(0, 4'b1000, 32'h5500_0000, 1,  1, 8'h55, 4'b1000, 1, 3, 0, 0);
        vecs[18] = v(0, 4'b1000, 32'h5500_0000, 1,  1, 8'h55, 4'b1000, 1, 3, 0, 0);
        vecs[19] = v(0, 4'b1000, 32'h5500_0000, 1,  1, 8'h55, 4'b1000, 1, 3, 0, 0);
        vecs[20] = v(0, 4'b1000, 32'h5500_0000, 1,  0, 8'h00, 4'b0000, 0, 3, 1, 1);
        vecs[21] = v(0, 4'b1000, 32'h5500_0000, 1,  1, 8'h55, 4'b1000, 1, 3, 0, 0);
        vecs[22] = v(0, 4'b1000, 32'h5500_0000, 1,  1, 8'h55, 4'b1000, 1, 3, 0, 0);
        vecs[23] = v(0, 4'b1000, 32'h5500_0000, 1,  1, 8'h55, 4'b1000, 1, 3, 0, 0);
        vecs[24] = v(0, 4'b1000, 32'h0A00_0000, 1,  1, 8'h0A, 4'b1000, 1, 3, 0, 0);
        // backpressure and owner dropping valid mid-line while req0 waits
        vecs[25] = v(0, 4'b0010, 32'h0000_3100, 0,  0, 8'h00, 4'b0000, 0, 3, 1, 0);
        vecs[26] = v(0, 4'b0010, 32'h0000_3100, 0,  1, 8'h31, 4'b0000, 1, 1, 0, 0);
        vecs[27] = v(0, 4'b0010, 32'h0000_3100, 1,  1, 8'h31, 4'b0010, 1, 1, 0, 0);
        vecs[28] = v(0, 4'b0001, 32'h0000_3200, 1,  0, 8'h00, 4'b0010, 1, 1, 0, 0);
        vecs[29] = v(0, 4'b0011, 32'h0000_3200, 0,  1, 8'h32, 4'b0000, 1, 1, 0, 0);
        vecs[30] = v(0, 4'b0011, 32'h0000_3200, 1,  1, 8'h32, 4'b0010, 1, 1, 0, 0);
        vecs[31] = v(0, 4'b0011, 32'h0000_0A00, 1,  1, 8'h0A, 4'b0010, 1, 1, 0, 0);
        // reset after 2 bytes of req2's line
        vecs[32] = v(0, 4'b0100, 32'h0061_0000, 1,  0, 8'h00, 4'b0000, 0, 1, 1, 0);
        vecs[33] = v(0, 4'b0100, 32'h0061_0000, 1,  1, 8'h61, 4'b0100, 1, 2, 0, 0);
        vecs[34] = v(0, 4'b0100, 32'h0062_0000, 1,  1, 8'h62, 4'b0100, 1, 2, 0, 0);
        vecs[35] = v(1, 4'b0110, 32'h0063_0A00, 1,  0, 8'h00, 4'b0000, 0, 0, 0, 0);
        vecs[36] = v(0, 4'b0110, 32'h0063_0A00, 1,  0, 8'h00, 4'b0000, 0, 0, 0, 0);
        vecs[37] = v(0, 4'b0110, 32'h0063_0A00, 1,  1, 8'h0A, 4'b0010, 1, 1, 0, 0);
        vecs[38] = v(0, 4'b0000, 32'h0000_0000, 1,  0, 8'h00, 4'b0000, 0, 1, 1, 0);
        vecs[39] = v(0, 4'b0000, 32'h0000_0000, 1,  0, 8'h00, 4'b0000, 0, 1, 0, 0);

        for (int i = 0; i < N_VEC; i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].rdy);
            check($sformatf("row%0d tx_valid", i), 32'(tx_valid_o), 32'(vecs[i].e_txv));
            if (vecs[i].e_txv)
                check($sformatf("row%0d tx_data", i), 32'(tx_data_o), 32'(vecs[i].e_txd));
            check($sformatf("row%0d req_ready", i), 32'(req_ready_o), 32'(vecs[i].e_ready));
            check($sformatf("row%0d locked", i), 32'(locked_o), 32'(vecs[i].e_lock));
            check($sformatf("row%0d owner", i), 32'(owner_o), 32'(vecs[i].e_owner));
            check($sformatf("row%0d line_done", i), 32'(line_done_o), 32'(vecs[i].e_done));
            if (vecs[i].e_done || vecs[i].rst)
                check($sformatf("row%0d done_cause", i), 32'(done_cause_o), 32'(vecs[i].e_cause));
        end

        // Stall: req0 sends one byte then drops valid while req1 waits.
        drive(0, 4'b0001, 32'h0000_005A, 1);
        check("stall grant idle", 32'(locked_o), 32'd0);
        drive(0, 4'b0001, 32'h0000_005A, 1);
        check("stall owner", 32'(owner_o), 32'd0);
        check("stall first byte", 32'(tx_data_o), 32'h5A);
        for (int c = 1; c <= TIMEOUT_CYCLES; c++) begin
            drive(0, 4'b0010, 32'h0000_3300, 1);
            check($sformatf("stall%0d locked", c), 32'(locked_o), 32'd1);
            check($sformatf("stall%0d tx_valid", c), 32'(tx_valid_o), 32'd0);
        end
`ifdef UART_ARB_TIMEOUT_EN
        drive(0, 4'b0010, 32'h0000_3300, 1);
        check("timeout locked", 32'(locked_o), 32'd0);
        check("timeout line_done", 32'(line_done_o), 32'd1);
        check("timeout cause", 32'(done_cause_o), 32'd2);
        drive(0, 4'b0010, 32'h0000_3300, 1);
        check("after timeout owner", 32'(owner_o), 32'd1);
        check("after timeout tx_data", 32'(tx_data_o), 32'h33);
        check("after timeout ready", 32'(req_ready_o), 32'b0010);
`else
        for (int c = 0; c < 24; c++) begin
            drive(0, 4'b0010, 32'h0000_3300, 1);
            check($sformatf("hold%0d locked", c), 32'(locked_o), 32'd1);
            check($sformatf("hold%0d line_done", c), 32'(line_done_o), 32'd0);
            check($sformatf("hold%0d owner", c), 32'(owner_o), 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_line_arbiter.md
UART_LINE_ARBITER -- requirements
Module: uart_line_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one UART transmitter, range 2..16.
REQ-002 SHALL have parameter MAX_LINE, default 255: maximum bytes per locked line before forced release, range 2..256.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: stall limit in clk_i cycles, used only under UART_ARB_TIMEOUT_EN.
REQ-004 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port req_valid_i, input, N_REQ: per-requester byte valid.
REQ-007 SHALL have port req_data_i, input, N_REQ*8: per-requester byte; requester k occupies bits [8k+7:8k].
REQ-008 SHALL have port req_ready_o, output, N_REQ: per-requester byte accepted.
REQ-009 SHALL have port tx_valid_o, output, 1: byte valid towards the UART serializer.
REQ-010 SHALL have port tx_data_o, output, 8: byte towards the UART serializer.
REQ-011 SHALL have port tx_ready_i, input, 1: serializer can take a byte this cycle.
REQ-012 SHALL have port owner_o, output, clog2(N_REQ): index of the current line owner.
REQ-013 SHALL have port locked_o, output, 1: a line is in progress.
REQ-014 SHALL have port line_done_o, output, 1: one-cycle pulse on line release.
REQ-015 SHALL have port done_cause_o, output, 2: release cause, valid with line_done_o: 0 = LF, 1 = MAX_LINE, 2 = timeout.

Function
REQ-016 SHALL implement FSM states IDLE and LOCKED.
REQ-017 IDLE: all req_ready_o = 0 and tx_valid_o = 0. If any req_valid_i bit is set, the FSM SHALL select the first set bit at or after rr_ptr, with wrap-around, then register owner_o and enter LOCKED on the next cycle. This gives a 1-cycle arbitration bubble.
REQ-018 LOCKED: tx_valid_o = req_valid_i[owner], tx_data_o = owner's byte, req_ready_o[owner] = tx_ready_i, and all other req_ready_o = 0. These paths are combinational, so there is zero added latency per byte.
REQ-019 A transfer SHALL occur only when tx_valid_o and tx_ready_i are both 1. Each transfer increments byte_cnt. byte_cnt is 8 bits wide and saturates by construction because of release.
REQ-020 A transfer with byte 8'h0A SHALL release the line with cause 0. The LF byte itself is forwarded.
REQ-021 A transfer with byte_cnt == MAX_LINE-1 that is not LF SHALL release the line with cause 1.
REQ-022 On a transfer that is both LF and the MAX_LINE-th byte, cause SHALL be 0. LF has priority.
REQ-023 Release SHALL do all of the following in the same cycle: assert line_done_o, go to IDLE, clear byte_cnt, and set rr_ptr = (owner+1) mod N_REQ.
REQ-024 A requester deasserting valid mid-line SHALL keep the lock. Other requesters SHALL wait.
REQ-025 A request present in the cycle of release SHALL NOT be granted until the following IDLE cycle. There is no same-cycle regrant.
REQ-026 owner_o SHALL hold its last value while in IDLE.

Reset
REQ-027 While rst_i = 1, the block SHALL force: FSM = IDLE, rr_ptr = 0, owner_o = 0, byte_cnt = 0, stall_cnt = 0, locked_o = 0, line_done_o = 0, done_cause_o = 0, tx_valid_o = 0, req_ready_o = 0.
REQ-028 Reset asserted mid-line SHALL abandon the line without asserting line_done_o. Any byte presented in that cycle is not transferred.

Configuration
REQ-029 With macro UART_ARB_TIMEOUT_EN defined: in LOCKED, stall_cnt SHALL count cycles in which req_valid_i[owner] = 0 and SHALL clear on any owner-valid cycle. When stall_cnt reaches TIMEOUT_CYCLES-1, the line SHALL release with cause 2.
REQ-030 Without UART_ARB_TIMEOUT_EN: stall_cnt SHALL be absent, the lock SHALL be held indefinitely, and cause 2 SHALL never occur.

Structure
REQ-031 Package uart_arb_pkg SHALL hold the FSM state enum, the done-cause enum, and the constant LF_CHAR = 8'h0A.
REQ-032 Round-robin selection SHALL live in sub-module uart_rr_sel, a combinational first-set-from-pointer search. The FSM, counters and muxing SHALL stay in uart_line_arbiter.

Verification
REQ-033 Single line: N_REQ=4; req1 sends "AB\n" with tx_ready_i=1. Required response: grant 1 cycle after valid, tx_data_o 41,42,0A on consecutive cycles, then line_done_o with cause 0 and owner_o=1.
REQ-034 Contention: req0 and req2 both valid from reset. Required response: req0 line completes first, and req2 is granted after exactly 1 IDLE cycle. On the next contention between req0 and req2, req2 wins, because rr_ptr=1 finds req2 first.
REQ-035 Max length: MAX_LINE=4; req3 streams 8'h55 without LF. Required response: release after the 4th byte with cause 1, then req3 regranted if still valid and no other requester is valid.
REQ-036 Backpressure: tx_ready_i toggles 1/0. Required response: req_ready_o[owner] mirrors tx_ready_i, and no byte is lost or duplicated.
REQ-037 Reset mid-line: assert rst_i after 2 of 5 bytes. Required response: outputs at reset values the next cycle, no line_done_o, and the next grant goes to the lowest valid index.
REQ-038 Timeout, with UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: owner stalls while req1 is waiting. Required response: release with cause 2 after 16 stalled cycles, then req1 granted. Without the macro, the lock persists.
